// File: rtl/hc112_seq_pkg.sv
// Shared types and helpers for the hc112_seq dual JK flip-flop sequencer.
// Opcodes, FSM states, per-op drive patterns and the expected-Q model.
package hc112_seq_pkg;

   typedef enum logic [2:0] {
      OpNop  = 3'b000,
      OpClr  = 3'b001,
      OpSet  = 3'b010,
      OpTog  = 3'b011,
      OpLoad = 3'b100,
      OpRead = 3'b101,
      OpIll6 = 3'b110,
      OpIll7 = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StEdge,
      StHold,
      StSample,
      StDone
   } state_e;

   typedef struct packed {
      logic j1;
      logic k1;
      logic j2;
      logic k2;
      logic rd1n;
      logic rd2n;
      logic sd1n;
      logic sd2n;
   } drive_t;

   localparam drive_t DriveIdle = '{j1: 1'b0, k1: 1'b0, j2: 1'b0, k2: 1'b0,
                                    rd1n: 1'b1, rd2n: 1'b1, sd1n: 1'b1, sd2n: 1'b1};

   function automatic logic is_legal(op_e op);
      return (op != OpIll6) && (op != OpIll7);
   endfunction

   // Flip-flops that receive a CPN pulse; bit0 = FF1, bit1 = FF2.
   function automatic logic [1:0] op_mask(op_e op, logic [1:0] arg);
      unique case (op)
         OpNop, OpLoad:        return 2'b11;
         OpClr, OpSet, OpTog:  return arg;
         default:              return 2'b00;
      endcase
   endfunction

   function automatic drive_t op_drive(op_e op, logic [1:0] arg);
      drive_t d;
      d = DriveIdle;
      unique case (op)
         OpClr: begin
            d.rd1n = ~arg[0];
            d.rd2n = ~arg[1];
         end
         OpSet: begin
            d.sd1n = ~arg[0];
            d.sd2n = ~arg[1];
         end
         OpTog: begin
            d.j1 = arg[0];
            d.k1 = arg[0];
            d.j2 = arg[1];
            d.k2 = arg[1];
         end
         OpLoad: begin
            d.j1 = arg[0];
            d.k1 = ~arg[0];
            d.j2 = arg[1];
            d.k2 = ~arg[1];
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic [1:0] expected_q(op_e op, logic [1:0] arg, logic [1:0] q_pre);
      unique case (op)
         OpClr:   return q_pre & ~arg;
         OpSet:   return q_pre | arg;
         OpTog:   return q_pre ^ arg;
         OpLoad:  return arg;
         default: return q_pre;
      endcase
   endfunction

endpackage

// File: rtl/hc112_seq_if.sv
// Requester handshake and flip-flop pin bundle for hc112_seq.
// master = requesters plus flip-flop outputs; slave = the sequencer.
interface hc112_seq_if;

   logic       REQ0;
   logic       REQ1;
   logic [2:0] OP0;
   logic [2:0] OP1;
   logic [1:0] ARG0;
   logic [1:0] ARG1;
   logic       ACK0;
   logic       ACK1;
   logic       ERR;
   logic [1:0] RDATA;
   logic       BUSY;
   logic       J1;
   logic       K1;
   logic       J2;
   logic       K2;
   logic       CPN1;
   logic       CPN2;
   logic       RD1N;
   logic       RD2N;
   logic       SD1N;
   logic       SD2N;
   logic       Q1;
   logic       Q2;

   modport master (
      output REQ0, REQ1, OP0, OP1, ARG0, ARG1, Q1, Q2,
      input  ACK0, ACK1, ERR, RDATA, BUSY,
      input  J1, K1, J2, K2, CPN1, CPN2, RD1N, RD2N, SD1N, SD2N
   );

   modport slave (
      input  REQ0, REQ1, OP0, OP1, ARG0, ARG1, Q1, Q2,
      output ACK0, ACK1, ERR, RDATA, BUSY,
      output J1, K1, J2, K2, CPN1, CPN2, RD1N, RD2N, SD1N, SD2N
   );

endinterface

// File: rtl/hc112_rr_arb.sv
// Two-way round-robin arbiter; grants only while gnt_en_i is high.
// The last-grant pointer resets so that requester 0 wins the first tie.
module hc112_rr_arb (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       gnt_en_i,
   output logic [1:0] gnt_o
);

   // 1 = requester 1 was granted last.
   logic last_q, last_d;

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (gnt_en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
      if (gnt_o != 2'b00) begin
         last_d = gnt_o[1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/hc112_seq.sv
// Command sequencer for a dual JK flip-flop package shared by two requesters.
// Define HC112_SEQ_VERIFY_EN to flag ops whose read-back Q differs from the expected value.
module hc112_seq
   import hc112_seq_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 1,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic         CP,
   input  logic         RDN,
   hc112_seq_if.slave   bus
);

   localparam logic [3:0] SetupLd = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PulseLd = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HoldLd  = 4'(HOLD_CYC - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   op_e        op_q, op_d;
   logic [1:0] arg_q, arg_d;
   logic       owner_q, owner_d;
   drive_t     drive_q, drive_d;
   logic [1:0] cpn_q, cpn_d;
   logic [1:0] ack_q, ack_d;
   logic       err_q, err_d;
   logic [1:0] rdata_q, rdata_d;

   logic [1:0] gnt;
   logic [1:0] q_now;
   op_e        sel_op;
   logic [1:0] sel_arg;

`ifdef HC112_SEQ_VERIFY_EN
   logic [1:0] q_pre_q, q_pre_d;
`endif

   assign q_now   = {bus.Q2, bus.Q1};
   assign sel_op  = op_e'(gnt[1] ? bus.OP1 : bus.OP0);
   assign sel_arg = gnt[1] ? bus.ARG1 : bus.ARG0;

   hc112_rr_arb u_arb (
      .clk_i    (CP),
      .rst_ni   (RDN),
      .req_i    ({bus.REQ1, bus.REQ0}),
      .gnt_en_i (state_q == StIdle),
      .gnt_o    (gnt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      arg_d   = arg_q;
      owner_d = owner_q;
      drive_d = drive_q;
      cpn_d   = cpn_q;
      ack_d   = 2'b00;
      err_d   = 1'b0;
      rdata_d = rdata_q;
`ifdef HC112_SEQ_VERIFY_EN
      q_pre_d = q_pre_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (gnt != 2'b00) begin
               owner_d = gnt[1];
               op_d    = sel_op;
               arg_d   = sel_arg;
               if (!is_legal(sel_op)) begin
                  state_d        = StDone;
                  ack_d[gnt[1]]  = 1'b1;
                  err_d          = 1'b1;
               end else if (sel_op == OpRead) begin
                  state_d = StSample;
               end else begin
                  state_d = StSetup;
                  cnt_d   = SetupLd;
                  drive_d = op_drive(sel_op, sel_arg);
`ifdef HC112_SEQ_VERIFY_EN
                  q_pre_d = q_now;
`endif
               end
            end
         end
         StSetup: begin
            if (cnt_q == 4'd0) begin
               state_d = StEdge;
               cnt_d   = PulseLd;
               cpn_d   = op_mask(op_q, arg_q);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StEdge: begin
            if (cnt_q == 4'd0) begin
               state_d = StHold;
               cnt_d   = HoldLd;
               cpn_d   = 2'b00;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_q == 4'd0) begin
               state_d = StSample;
               drive_d = DriveIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StSample: begin
            state_d         = StDone;
            rdata_d         = q_now;
            ack_d[owner_q]  = 1'b1;
`ifdef HC112_SEQ_VERIFY_EN
            // READ never passed through SETUP, so it has no pre-op snapshot to compare.
            err_d = (op_q != OpRead) && (q_now != expected_q(op_q, arg_q, q_pre_q));
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CP or negedge RDN) begin
      if (!RDN) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         op_q    <= OpNop;
         arg_q   <= 2'b00;
         owner_q <= 1'b0;
         drive_q <= DriveIdle;
         cpn_q   <= 2'b00;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         rdata_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         arg_q   <= arg_d;
         owner_q <= owner_d;
         drive_q <= drive_d;
         cpn_q   <= cpn_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef HC112_SEQ_VERIFY_EN
   always_ff @(posedge CP or negedge RDN) begin
      if (!RDN) begin
         q_pre_q <= 2'b00;
      end else begin
         q_pre_q <= q_pre_d;
      end
   end
`endif

   assign bus.ACK0  = ack_q[0];
   assign bus.ACK1  = ack_q[1];
   assign bus.ERR   = err_q;
   assign bus.RDATA = rdata_q;
   assign bus.BUSY  = (state_q != StIdle);
   assign bus.J1    = drive_q.j1;
   assign bus.K1    = drive_q.k1;
   assign bus.J2    = drive_q.j2;
   assign bus.K2    = drive_q.k2;
   assign bus.RD1N  = drive_q.rd1n;
   assign bus.RD2N  = drive_q.rd2n;
   assign bus.SD1N  = drive_q.sd1n;
   assign bus.SD2N  = drive_q.sd2n;
   assign bus.CPN1  = cpn_q[0];
   assign bus.CPN2  = cpn_q[1];

endmodule

// File: tb/tb_hc112_seq.sv
// Directed self-checking bench for hc112_seq with a behavioural dual JK flip-flop.
// Expected ERR for the stuck-Q step follows HC112_SEQ_VERIFY_EN.
module tb_hc112_seq;

   logic cp  = 1'b0;
   logic rdn = 1'b0;

   hc112_seq_if bus ();

   hc112_seq u_dut (
      .CP  (cp),
      .RDN (rdn),
      .bus (bus)
   );

   always #5 cp = ~cp;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_cpn1   = 0;
   int n_cpn2   = 0;
   int base1    = 0;
   int base2    = 0;

   logic ff1_q  = 1'b0;
   logic ff2_q  = 1'b0;
   logic stuck1 = 1'b0;

   assign bus.Q1 = stuck1 ? 1'b0 : ff1_q;
   assign bus.Q2 = ff2_q;

   // Rising-edge JK flip-flops with asynchronous reset/set-direct.
   always @(posedge bus.CPN1 or negedge bus.RD1N or negedge bus.SD1N) begin
      if (!bus.RD1N)      ff1_q <= 1'b0;
      else if (!bus.SD1N) ff1_q <= 1'b1;
      else if (bus.CPN1) begin
         case ({bus.J1, bus.K1})
            2'b01:   ff1_q <= 1'b0;
            2'b10:   ff1_q <= 1'b1;
            2'b11:   ff1_q <= ~ff1_q;
            default: ff1_q <= ff1_q;
         endcase
      end
   end

   always @(posedge bus.CPN2 or negedge bus.RD2N or negedge bus.SD2N) begin
      if (!bus.RD2N)      ff2_q <= 1'b0;
      else if (!bus.SD2N) ff2_q <= 1'b1;
      else if (bus.CPN2) begin
         case ({bus.J2, bus.K2})
            2'b01:   ff2_q <= 1'b0;
            2'b10:   ff2_q <= 1'b1;
            2'b11:   ff2_q <= ~ff2_q;
            default: ff2_q <= ff2_q;
         endcase
      end
   end

   always @(posedge bus.CPN1) n_cpn1++;
   always @(posedge bus.CPN2) n_cpn2++;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cp);
      #1;
   endtask

   task automatic start_op(input int id, input logic [2:0] op, input logic [1:0] arg);
      base1 = n_cpn1;
      base2 = n_cpn2;
      if (id == 0) begin
         bus.OP0  = op;
         bus.ARG0 = arg;
         bus.REQ0 = 1'b1;
      end else begin
         bus.OP1  = op;
         bus.ARG1 = arg;
         bus.REQ1 = 1'b1;
      end
   endtask

   task automatic wait_ack(input int id, input int lat0, output int lat);
      lat = lat0;
      for (int i = 0; i < 40; i++) begin
         tick();
         lat++;
         if ((id == 0 && bus.ACK0 === 1'b1) || (id == 1 && bus.ACK1 === 1'b1)) break;
      end
   endtask

   task automatic run_op(input string tag, input int id, input logic [2:0] op,
                         input logic [1:0] arg, input int lat0, input int exp_lat,
                         input logic [1:0] exp_rdata, input logic exp_err);
      int lat;
      wait_ack(id, lat0, lat);
      check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
      check({tag, "_rdata"}, {6'd0, bus.RDATA}, {6'd0, exp_rdata});
      check({tag, "_err"}, {7'd0, bus.ERR}, {7'd0, exp_err});
      check({tag, "_other_ack"}, {7'd0, (id == 0) ? bus.ACK1 : bus.ACK0}, 8'd0);
      check({tag, "_busy"}, {7'd0, bus.BUSY}, 8'd1);
      if (id == 0) bus.REQ0 = 1'b0;
      else         bus.REQ1 = 1'b0;
      tick();
   endtask

   initial begin
      logic exp_verify_err;
      int   who;
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;
      bus.OP0  = 3'b000;
      bus.OP1  = 3'b000;
      bus.ARG0 = 2'b00;
      bus.ARG1 = 2'b00;

      // Reset state
      tick();
      tick();
      check("rst_busy", {7'd0, bus.BUSY}, 8'd0);
      check("rst_ack", {6'd0, bus.ACK1, bus.ACK0}, 8'd0);
      check("rst_err", {7'd0, bus.ERR}, 8'd0);
      check("rst_rdata", {6'd0, bus.RDATA}, 8'd0);
      check("rst_cpn", {6'd0, bus.CPN2, bus.CPN1}, 8'd0);
      check("rst_jk", {4'd0, bus.J2, bus.K2, bus.J1, bus.K1}, 8'd0);
      check("rst_rdsd", {4'd0, bus.RD2N, bus.RD1N, bus.SD2N, bus.SD1N}, 8'h0f);
      rdn = 1'b1;
      tick();

      // LOAD 10 from 00
      start_op(0, 3'b100, 2'b10);
      tick();
      check("load_jk", {4'd0, bus.J2, bus.K2, bus.J1, bus.K1}, 8'b1001);
      check("load_busy_setup", {7'd0, bus.BUSY}, 8'd1);
      run_op("load", 0, 3'b100, 2'b10, 1, 5, 2'b10, 1'b0);
      check("load_cpn1_edges", 8'(n_cpn1 - base1), 8'd1);
      check("load_cpn2_edges", 8'(n_cpn2 - base2), 8'd1);

      // TOG mask 01 from 10
      start_op(1, 3'b011, 2'b01);
      run_op("tog", 1, 3'b011, 2'b01, 0, 5, 2'b11, 1'b0);
      check("tog_cpn1_edges", 8'(n_cpn1 - base1), 8'd1);
      check("tog_cpn2_edges", 8'(n_cpn2 - base2), 8'd0);

      // READ: no clock edges
      start_op(0, 3'b101, 2'b00);
      run_op("read", 0, 3'b101, 2'b00, 0, 2, 2'b11, 1'b0);
      check("read_edges", 8'((n_cpn1 - base1) + (n_cpn2 - base2)), 8'd0);

      // Illegal opcode: RDATA untouched
      start_op(1, 3'b111, 2'b11);
      run_op("ill", 1, 3'b111, 2'b11, 0, 1, 2'b11, 1'b1);
      check("ill_edges", 8'((n_cpn1 - base1) + (n_cpn2 - base2)), 8'd0);

      // CLR both from 11
      start_op(0, 3'b001, 2'b11);
      tick();
      check("clr_rdn", {6'd0, bus.RD2N, bus.RD1N}, 8'd0);
      run_op("clr", 0, 3'b001, 2'b11, 1, 5, 2'b00, 1'b0);

      // Q1 stuck at 0, SET mask 01
`ifdef HC112_SEQ_VERIFY_EN
      exp_verify_err = 1'b1;
`else
      exp_verify_err = 1'b0;
`endif
      stuck1 = 1'b1;
      start_op(1, 3'b010, 2'b01);
      run_op("stuck_set", 1, 3'b010, 2'b01, 0, 5, 2'b00, exp_verify_err);
      stuck1 = 1'b0;

      // Contention from reset: expect 0,1,0,1
      rdn = 1'b0;
      bus.OP0  = 3'b101;
      bus.OP1  = 3'b101;
      bus.REQ0 = 1'b1;
      bus.REQ1 = 1'b1;
      tick();
      rdn = 1'b1;
      for (int n = 0; n < 4; n++) begin
         who = 2;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ACK0 === 1'b1) begin
               who = 0;
               break;
            end
            if (bus.ACK1 === 1'b1) begin
               who = 1;
               break;
            end
         end
         check($sformatf("rr_order%0d", n), 8'(who), 8'(n % 2));
      end
      check("rr_rdata", {6'd0, bus.RDATA}, 8'b01);
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;
      tick();
      tick();

      // Reset mid-EDGE
      start_op(0, 3'b011, 2'b01);
      tick();
      tick();
      check("edge_cpn1", {7'd0, bus.CPN1}, 8'd1);
      #2;
      rdn = 1'b0;
      bus.REQ0 = 1'b0;
      #1;
      check("abort_cpn1", {7'd0, bus.CPN1}, 8'd0);
      check("abort_busy", {7'd0, bus.BUSY}, 8'd0);
      check("abort_rdata", {6'd0, bus.RDATA}, 8'd0);
      check("abort_jk", {4'd0, bus.J2, bus.K2, bus.J1, bus.K1}, 8'd0);
      tick();
      check("abort_ack", {6'd0, bus.ACK1, bus.ACK0}, 8'd0);
      rdn = 1'b1;
      tick();
      tick();
      check("abort_idle", {5'd0, bus.BUSY, bus.ACK1, bus.ACK0}, 8'd0);
      check("abort_cpn1_edges", 8'(n_cpn1 - base1), 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
